adc_pkt_framer: RTL

ADC_PKT_FRAMER -- requirements
Module: adc_pkt_framer

---
 rtl/adc_pkt_framer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/adc_pkt_framer.sv
// adc_pkt_framer: packs sign-extended two-lane ADC samples into AXI-Stream packets of pkt_len beats.
// Latency: one cycle from an accepted input beat to m_axi_tvalid when the skid FIFO is empty.
// Backpressure: s_axi_tready is registered and drops two entries early; late beats are absorbed, beats hitting a full FIFO are dropped (sticky overflow).
//
// Ports:
//   s_axi_aclk / s_axi_reset         single clock, synchronous active-high reset
//   enable, pkt_len                  capture enable (level) and beats per packet (sampled on IDLE->RUN)
//   s_axi_tvalid/tdata/tready        upstream sample stream, lane1 in [31:16], lane0 in [15:0]
//   m_axi_tvalid/tdata/tlast/tready  downstream packet stream
//   frame_cnt, overflow              completed-packet count, sticky lost-beat flag
//
// Optional build macro ADC_PKT_HEADER_EN: prefixes every packet with a {16'hADC0, frame_cnt}
// header beat, emitted only once the packet's first data beat is sitting in the FIFO.
module adc_pkt_framer #(
    parameter int DATA_WIDTH        = 14,
    parameter int C_AXI_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                         s_axi_aclk,
    input  logic                         s_axi_reset,
    input  logic                         enable,
    input  logic [15:0]                  pkt_len,
    input  logic                         s_axi_tvalid,
    input  logic [C_AXI_TDATA_WIDTH-1:0] s_axi_tdata,
    output logic                         s_axi_tready,
    output logic                         m_axi_tvalid,
    output logic [C_AXI_TDATA_WIDTH-1:0] m_axi_tdata,
    output logic                         m_axi_tlast,
    input  logic                         m_axi_tready,
    output logic [15:0]                  frame_cnt,
    output logic                         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_M2 = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                         state_q, state_d;
    logic [C_AXI_TDATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]                  wr_ptr_q, rd_ptr_q;
    logic [AW:0]                    count_q, count_d;
    logic [15:0]                    len_q, len_d;
    logic [15:0]                    beat_q, beat_d;
    logic [15:0]                    frame_q, frame_d;
    logic                           ovf_q, ovf_d;
    logic                           s_rdy_q, s_rdy_d;

    logic [C_AXI_TDATA_WIDTH-1:0]   wr_dat;
    logic                           fifo_empty, fifo_full;
    logic                           push, pop, out_hs;
    logic                           data_last;
    logic                           start;
    logic                           hdr_active;

    // Lane bits above DATA_WIDTH-1 are deliberately ignored.
    logic unused_tdata;
    assign unused_tdata = ^s_axi_tdata;

    // Sign-extend each 16-bit lane from bit DATA_WIDTH-1.
    always_comb begin
        wr_dat = '0;
        for (int i = 0; i < 16; i++) begin
            wr_dat[i]    = (i < DATA_WIDTH) ? s_axi_tdata[i]      : s_axi_tdata[DATA_WIDTH-1];
            wr_dat[16+i] = (i < DATA_WIDTH) ? s_axi_tdata[16+i]   : s_axi_tdata[16+DATA_WIDTH-1];
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign out_hs     = !fifo_empty && m_axi_tready;
    // A header handshake does not consume a FIFO entry.
    assign pop        = out_hs && !hdr_active;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push       = (state_q == RUN) && s_axi_tvalid && (!fifo_full || pop);

    // End of packet: counter reached the latched length, or the last beat left while draining.
    assign data_last  = (beat_q == len_q - 16'd1) ||
                        ((state_q == DRAIN) && (count_q == CNT_ONE));

    assign m_axi_tvalid = !fifo_empty;
    assign m_axi_tlast  = !fifo_empty && !hdr_active && data_last;
    assign s_axi_tready = s_rdy_q;
    assign frame_cnt    = frame_q;
    assign overflow     = ovf_q;

`ifdef ADC_PKT_HEADER_EN
    logic hdr_pend_q, hdr_pend_d;

    assign hdr_active  = hdr_pend_q && !fifo_empty;
    assign m_axi_tdata = fifo_empty ? '0 :
                         hdr_active ? {16'hADC0, frame_q} : mem_q[rd_ptr_q];

    always_comb begin
        hdr_pend_d = hdr_pend_q;
        if (out_hs && hdr_active) hdr_pend_d = 1'b0;
        if (pop && m_axi_tlast)   hdr_pend_d = 1'b1;
        if (start)                hdr_pend_d = 1'b1;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_reset) hdr_pend_q <= 1'b0;
        else             hdr_pend_q <= hdr_pend_d;
    end
`else
    assign hdr_active  = 1'b0;
    assign m_axi_tdata = fifo_empty ? '0 : mem_q[rd_ptr_q];
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        frame_d = frame_q;
        ovf_d   = ovf_q;
        start   = 1'b0;

        case (state_q)
            IDLE:    if (enable) begin
                         state_d = RUN;
                         start   = 1'b1;
                     end
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (pop) begin
            if (m_axi_tlast) begin
                beat_d  = '0;
                frame_d = frame_q + 16'd1;
            end else begin
                beat_d  = beat_q + 16'd1;
            end
        end

        if ((state_q == RUN) && s_axi_tvalid && fifo_full && !pop) ovf_d = 1'b1;

        if (start) begin
            len_d  = (pkt_len == 16'd0) ? 16'd1 : pkt_len;
            beat_d = '0;
            ovf_d  = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Two slots of headroom cover the beat already in flight behind the registered ready.
        s_rdy_d = (state_d == RUN) && (count_d <= DEPTH_M2);
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            frame_q  <= '0;
            ovf_q    <= 1'b0;
            s_rdy_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            frame_q  <= frame_d;
            ovf_q    <= ovf_d;
            s_rdy_q  <= s_rdy_d;
        end
    end

    // Storage needs no reset: an empty FIFO masks the head on m_axi_tdata.
    always_ff @(posedge s_axi_aclk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat;
    end

endmodule
